// File: rtl/memory_access_stage.sv
// Memory access stage: issues data-cache requests for loads/stores, aligns lanes, registers writeback.
// Optional: define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module memory_access_stage #(
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADD_WIDTH    = 5,
  parameter int unsigned D_CACHE_LW_WIDTH = 3,
  parameter int unsigned D_CACHE_SW_WIDTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        STALL_MEMORY_STAGE,
  input  logic                        CLEAR_MEMORY_STAGE,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
  input  logic [DATA_WIDTH-1:0]       ALU_OUT,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
  input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
  input  logic [DATA_WIDTH-1:0]       DATA_CACHE_STORE_DATA,
  input  logic                        WRITE_BACK_MUX_SELECT_IN,
  input  logic                        RD_WRITE_ENABLE_IN,
  output logic                        DCACHE_REQ,
  output logic                        DCACHE_WE,
  output logic [ADDRESS_WIDTH-1:0]    DCACHE_ADDR,
  output logic [3:0]                  DCACHE_WSTRB,
  output logic [DATA_WIDTH-1:0]       DCACHE_WDATA,
  input  logic                        DCACHE_READY,
  input  logic [DATA_WIDTH-1:0]       DCACHE_RDATA,
  output logic                        MEMORY_BUSY,
  output logic                        MISALIGNED,
  output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
  output logic [DATA_WIDTH-1:0]       WRITE_BACK_DATA,
  output logic                        RD_WRITE_ENABLE_OUT
);

  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LB  = D_CACHE_LW_WIDTH'(1);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LH  = D_CACHE_LW_WIDTH'(2);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LW  = D_CACHE_LW_WIDTH'(3);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LBU = D_CACHE_LW_WIDTH'(4);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LHU = D_CACHE_LW_WIDTH'(5);
  localparam logic [D_CACHE_SW_WIDTH-1:0] ST_NONE = D_CACHE_SW_WIDTH'(0);
  localparam logic [D_CACHE_SW_WIDTH-1:0] ST_SB   = D_CACHE_SW_WIDTH'(1);
  localparam logic [D_CACHE_SW_WIDTH-1:0] ST_SH   = D_CACHE_SW_WIDTH'(2);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state;
  logic                    is_store, is_load, mem_op;
  logic                    sz_byte, sz_half, sz_word, ld_signed;
  logic [1:0]              addr_lo;
  logic                    trap_c, issue_c, complete_c;
  logic                    pend_valid;
  logic [DATA_WIDTH-1:0]   pend_rdata, rdata_sel, load_data, wb_capture_c;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;

  assign addr_lo = ALU_OUT[1:0];

  // Op decode: a store wins over a simultaneous load code
  always_comb begin
    is_store  = 1'b0;
    is_load   = 1'b0;
    sz_byte   = 1'b0;
    sz_half   = 1'b0;
    sz_word   = 1'b0;
    ld_signed = 1'b0;
    if (DATA_CACHE_STORE_IN != ST_NONE) begin
      is_store = 1'b1;
      if (DATA_CACHE_STORE_IN == ST_SB)      sz_byte = 1'b1;
      else if (DATA_CACHE_STORE_IN == ST_SH) sz_half = 1'b1;
      else                                   sz_word = 1'b1;
    end else begin
      case (DATA_CACHE_LOAD_IN)
        LD_LB:  begin is_load = 1'b1; sz_byte = 1'b1; ld_signed = 1'b1; end
        LD_LH:  begin is_load = 1'b1; sz_half = 1'b1; ld_signed = 1'b1; end
        LD_LW:  begin is_load = 1'b1; sz_word = 1'b1; end
        LD_LBU: begin is_load = 1'b1; sz_byte = 1'b1; end
        LD_LHU: begin is_load = 1'b1; sz_half = 1'b1; end
        default: ;
      endcase
    end
  end

  assign mem_op = is_store | is_load;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap_c = mem_op & ((sz_half & addr_lo[0]) | (sz_word & (addr_lo != 2'b00)));
`else
  assign trap_c = 1'b0;
`endif

  // Cache handshake; a result parked under stall blocks re-issue of the same op
  assign issue_c     = RST_N & (state == S_IDLE) & mem_op & ~trap_c &
                       ~STALL_MEMORY_STAGE & ~pend_valid;
  assign DCACHE_REQ  = issue_c | (RST_N & (state == S_WAIT));
  assign MEMORY_BUSY = DCACHE_REQ & ~DCACHE_READY;
  assign complete_c  = DCACHE_REQ & DCACHE_READY;
  assign DCACHE_WE   = DCACHE_REQ & is_store;
  assign DCACHE_ADDR = ADDRESS_WIDTH'(ALU_OUT) & ~ADDRESS_WIDTH'(3);

  // Store lane steering; halfwords use addr[1] only
  always_comb begin
    DCACHE_WSTRB = 4'b0000;
    DCACHE_WDATA = DATA_CACHE_STORE_DATA;
    if (is_store) begin
      if (sz_byte) begin
        DCACHE_WSTRB = 4'b0001 << addr_lo;
        DCACHE_WDATA = DATA_WIDTH'({4{DATA_CACHE_STORE_DATA[7:0]}});
      end else if (sz_half) begin
        DCACHE_WSTRB = 4'b0011 << {addr_lo[1], 1'b0};
        DCACHE_WDATA = DATA_WIDTH'({2{DATA_CACHE_STORE_DATA[15:0]}});
      end else begin
        DCACHE_WSTRB = 4'b1111;
      end
    end
  end

  // Load lane extraction with sign/zero extension
  assign rdata_sel = pend_valid ? pend_rdata : DCACHE_RDATA;
  assign ld_byte   = rdata_sel[{addr_lo, 3'b000} +: 8];
  assign ld_half   = addr_lo[1] ? rdata_sel[31:16] : rdata_sel[15:0];

  always_comb begin
    load_data = rdata_sel;
    if (sz_byte)
      load_data = {{(DATA_WIDTH-8){ld_signed & ld_byte[7]}}, ld_byte};
    else if (sz_half)
      load_data = {{(DATA_WIDTH-16){ld_signed & ld_half[15]}}, ld_half};
  end

  assign wb_capture_c = WRITE_BACK_MUX_SELECT_IN ? load_data : ALU_OUT;

  // FSM, parked-result register and writeback output register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state               <= S_IDLE;
      pend_valid          <= 1'b0;
      pend_rdata          <= '0;
      RD_ADDRESS_OUT      <= '0;
      WRITE_BACK_DATA     <= '0;
      RD_WRITE_ENABLE_OUT <= 1'b0;
      MISALIGNED          <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (issue_c && !DCACHE_READY) state <= S_WAIT;
      end else if (DCACHE_READY) begin
        state <= S_IDLE;
      end

      if (CLEAR_MEMORY_STAGE || !STALL_MEMORY_STAGE) begin
        pend_valid <= 1'b0;
      end else if (complete_c) begin
        pend_valid <= 1'b1;
        pend_rdata <= DCACHE_RDATA;
      end

      if (CLEAR_MEMORY_STAGE || (!STALL_MEMORY_STAGE && MEMORY_BUSY)) begin
        RD_ADDRESS_OUT      <= '0;
        WRITE_BACK_DATA     <= '0;
        RD_WRITE_ENABLE_OUT <= 1'b0;
        MISALIGNED          <= 1'b0;
      end else if (!STALL_MEMORY_STAGE) begin
        RD_ADDRESS_OUT <= RD_ADDRESS_IN;
        if (complete_c || pend_valid) begin
          WRITE_BACK_DATA     <= wb_capture_c;
          RD_WRITE_ENABLE_OUT <= RD_WRITE_ENABLE_IN;
          MISALIGNED          <= 1'b0;
        end else if (trap_c) begin
          WRITE_BACK_DATA     <= ALU_OUT;
          RD_WRITE_ENABLE_OUT <= 1'b0;
          MISALIGNED          <= 1'b1;
        end else begin
          WRITE_BACK_DATA     <= ALU_OUT;
          RD_WRITE_ENABLE_OUT <= RD_WRITE_ENABLE_IN;
          MISALIGNED          <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: expected writebacks queued at issue, popped at capture.
module tb_memory_access_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        STALL_MEMORY_STAGE, CLEAR_MEMORY_STAGE;
  logic [4:0]  RD_ADDRESS_IN;
  logic [31:0] ALU_OUT;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic [31:0] DATA_CACHE_STORE_DATA;
  logic        WRITE_BACK_MUX_SELECT_IN, RD_WRITE_ENABLE_IN;
  logic        DCACHE_REQ, DCACHE_WE;
  logic [31:0] DCACHE_ADDR;
  logic [3:0]  DCACHE_WSTRB;
  logic [31:0] DCACHE_WDATA;
  logic        DCACHE_READY;
  logic [31:0] DCACHE_RDATA;
  logic        MEMORY_BUSY, MISALIGNED;
  logic [4:0]  RD_ADDRESS_OUT;
  logic [31:0] WRITE_BACK_DATA;
  logic        RD_WRITE_ENABLE_OUT;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  memory_access_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .STALL_MEMORY_STAGE(STALL_MEMORY_STAGE), .CLEAR_MEMORY_STAGE(CLEAR_MEMORY_STAGE),
    .RD_ADDRESS_IN(RD_ADDRESS_IN), .ALU_OUT(ALU_OUT),
    .DATA_CACHE_LOAD_IN(DATA_CACHE_LOAD_IN), .DATA_CACHE_STORE_IN(DATA_CACHE_STORE_IN),
    .DATA_CACHE_STORE_DATA(DATA_CACHE_STORE_DATA),
    .WRITE_BACK_MUX_SELECT_IN(WRITE_BACK_MUX_SELECT_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
    .DCACHE_REQ(DCACHE_REQ), .DCACHE_WE(DCACHE_WE), .DCACHE_ADDR(DCACHE_ADDR),
    .DCACHE_WSTRB(DCACHE_WSTRB), .DCACHE_WDATA(DCACHE_WDATA),
    .DCACHE_READY(DCACHE_READY), .DCACHE_RDATA(DCACHE_RDATA),
    .MEMORY_BUSY(MEMORY_BUSY), .MISALIGNED(MISALIGNED),
    .RD_ADDRESS_OUT(RD_ADDRESS_OUT), .WRITE_BACK_DATA(WRITE_BACK_DATA),
    .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] alu,
                       input logic [31:0] sdata, input logic sel, input logic [4:0] rd,
                       input logic wen);
    DATA_CACHE_LOAD_IN       = ld;
    DATA_CACHE_STORE_IN      = st;
    ALU_OUT                  = alu;
    DATA_CACHE_STORE_DATA    = sdata;
    WRITE_BACK_MUX_SELECT_IN = sel;
    RD_ADDRESS_IN            = rd;
    RD_WRITE_ENABLE_IN       = wen;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_wb"}, WRITE_BACK_DATA, e.wb);
      check({tag, "_rd"}, 32'(RD_ADDRESS_OUT), 32'(e.rd));
      check({tag, "_we"}, 32'(RD_WRITE_ENABLE_OUT), 32'(e.we));
      check({tag, "_mis"}, 32'(MISALIGNED), 32'd0);
    end
  endtask

  // One cache transaction with READY held off for 'delay' cycles
  task automatic run_op(input string tag, input logic [2:0] ld, input logic [1:0] st,
                        input logic [31:0] alu, input logic [31:0] sdata, input logic sel,
                        input logic [4:0] rd, input logic wen, input logic [31:0] rdata,
                        input int delay, input logic [31:0] e_addr, input logic [3:0] e_wstrb,
                        input logic [31:0] e_wdata, input logic [31:0] e_wb);
    int busy_n;
    busy_n = 0;
    @(negedge CLK);
    drive(ld, st, alu, sdata, sel, rd, wen);
    DCACHE_READY = (delay == 0);
    DCACHE_RDATA = rdata;
    sb.push_back('{rd, e_wb, wen});
    #1;
    check({tag, "_req"}, 32'(DCACHE_REQ), 32'd1);
    check({tag, "_addr"}, DCACHE_ADDR, e_addr);
    check({tag, "_wstrb"}, 32'(DCACHE_WSTRB), 32'(e_wstrb));
    check({tag, "_dwe"}, 32'(DCACHE_WE), 32'(st != 2'b00));
    if (st != 2'b00) check({tag, "_wdata"}, DCACHE_WDATA, e_wdata);
    if (MEMORY_BUSY) busy_n++;
    for (int i = 0; i < delay; i++) begin
      @(posedge CLK); #1;
      check({tag, "_bubble_wb"}, WRITE_BACK_DATA, 32'd0);
      check({tag, "_bubble_we"}, 32'(RD_WRITE_ENABLE_OUT), 32'd0);
      @(negedge CLK);
      if (i == delay - 1) DCACHE_READY = 1'b1;
      #1;
      check({tag, "_hold_req"}, 32'(DCACHE_REQ), 32'd1);
      check({tag, "_hold_addr"}, DCACHE_ADDR, e_addr);
      if (MEMORY_BUSY) busy_n++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(delay));
    @(posedge CLK); #1;
    DCACHE_READY = 1'b0;
    compare_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    STALL_MEMORY_STAGE = 1'b0;
    CLEAR_MEMORY_STAGE = 1'b0;
    DCACHE_READY = 1'b0;
    DCACHE_RDATA = 32'h0;
    drive(3'b011, 2'b00, 32'h100, 32'h0, 1'b1, 5'd5, 1'b1);
    #12;
    check("rst_req", 32'(DCACHE_REQ), 32'd0);
    check("rst_busy", 32'(MEMORY_BUSY), 32'd0);
    check("rst_wb", WRITE_BACK_DATA, 32'd0);
    check("rst_rd", 32'(RD_ADDRESS_OUT), 32'd0);
    check("rst_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    check("rst_mis", 32'(MISALIGNED), 32'd0);
    drive(3'b000, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Non-memory pass-through
    @(negedge CLK);
    drive(3'b000, 2'b00, 32'h55, 32'h0, 1'b0, 5'd7, 1'b1);
    sb.push_back('{5'd7, 32'h55, 1'b1});
    #1 check("alu_req", 32'(DCACHE_REQ), 32'd0);
    @(posedge CLK); #1 compare_out("alu");

    run_op("lw",  3'b011, 2'b00, 32'h100, 32'h0, 1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 0,
           32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
    run_op("lb",  3'b001, 2'b00, 32'h103, 32'h0, 1'b1, 5'd6, 1'b1, 32'h80FF0000, 3,
           32'h100, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_op("lbu", 3'b100, 2'b00, 32'h103, 32'h0, 1'b1, 5'd6, 1'b1, 32'h80FF0000, 3,
           32'h100, 4'b0000, 32'h0, 32'h00000080);
    run_op("lh",  3'b010, 2'b00, 32'h102, 32'h0, 1'b1, 5'd11, 1'b1, 32'h80011234, 1,
           32'h100, 4'b0000, 32'h0, 32'hFFFF8001);
    run_op("lhu", 3'b101, 2'b00, 32'h100, 32'h0, 1'b1, 5'd12, 1'b1, 32'h00009234, 0,
           32'h100, 4'b0000, 32'h0, 32'h00009234);
    run_op("sh",  3'b000, 2'b10, 32'h202, 32'h1234ABCD, 1'b0, 5'd3, 1'b0, 32'h0, 0,
           32'h200, 4'b1100, 32'hABCDABCD, 32'h202);
    run_op("sb",  3'b000, 2'b01, 32'h201, 32'h0000005A, 1'b0, 5'd0, 1'b0, 32'h0, 0,
           32'h200, 4'b0010, 32'h5A5A5A5A, 32'h201);
    run_op("sw",  3'b001, 2'b11, 32'h204, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 32'h0, 2,
           32'h204, 4'b1111, 32'hCAFEF00D, 32'h204);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    @(negedge CLK);
    drive(3'b011, 2'b00, 32'h101, 32'h0, 1'b1, 5'd8, 1'b1);
    #1;
    check("mis_req", 32'(DCACHE_REQ), 32'd0);
    check("mis_busy", 32'(MEMORY_BUSY), 32'd0);
    @(posedge CLK); #1;
    check("mis_flag", 32'(MISALIGNED), 32'd1);
    check("mis_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    @(negedge CLK);
    drive(3'b000, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(posedge CLK); #1;
    check("mis_clear", 32'(MISALIGNED), 32'd0);
`else
    run_op("mis", 3'b011, 2'b00, 32'h101, 32'h0, 1'b1, 5'd8, 1'b1, 32'h0A0B0C0D, 0,
           32'h100, 4'b0000, 32'h0, 32'h0A0B0C0D);
`endif

    // Stall arriving mid-WAIT: result parked, captured once the stall drops
    @(negedge CLK);
    drive(3'b011, 2'b00, 32'h300, 32'h0, 1'b1, 5'd9, 1'b1);
    DCACHE_RDATA = 32'h11223344;
    sb.push_back('{5'd9, 32'h11223344, 1'b1});
    #1 check("stw_busy", 32'(MEMORY_BUSY), 32'd1);
    @(posedge CLK); #1 check("stw_bubble", WRITE_BACK_DATA, 32'd0);
    @(negedge CLK);
    STALL_MEMORY_STAGE = 1'b1;
    #1 check("stw_req_wait", 32'(DCACHE_REQ), 32'd1);
    @(negedge CLK);
    DCACHE_READY = 1'b1;
    #1 check("stw_busy_ready", 32'(MEMORY_BUSY), 32'd0);
    @(posedge CLK); #1;
    DCACHE_READY = 1'b0;
    check("stw_held", WRITE_BACK_DATA, 32'd0);
    @(negedge CLK); #1 check("stw_no_reissue", 32'(DCACHE_REQ), 32'd0);
    @(negedge CLK);
    STALL_MEMORY_STAGE = 1'b0;
    DCACHE_RDATA = 32'h0;
    #1 check("stw_no_reissue2", 32'(DCACHE_REQ), 32'd0);
    @(posedge CLK); #1 compare_out("stw");

    // Stall blocks new requests and holds output; clear beats stall
    @(negedge CLK);
    drive(3'b011, 2'b00, 32'h100, 32'h0, 1'b1, 5'd2, 1'b1);
    STALL_MEMORY_STAGE = 1'b1;
    #1 check("stall_req", 32'(DCACHE_REQ), 32'd0);
    @(posedge CLK); #1 check("stall_hold", WRITE_BACK_DATA, 32'h11223344);
    @(negedge CLK);
    CLEAR_MEMORY_STAGE = 1'b1;
    @(posedge CLK); #1;
    check("clr_wb", WRITE_BACK_DATA, 32'd0);
    check("clr_rd", 32'(RD_ADDRESS_OUT), 32'd0);
    check("clr_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    @(negedge CLK);
    CLEAR_MEMORY_STAGE = 1'b0;
    STALL_MEMORY_STAGE = 1'b0;
    drive(3'b000, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);

    // Reset asserted during WAIT abandons the transaction
    @(negedge CLK);
    drive(3'b011, 2'b00, 32'h400, 32'h0, 1'b1, 5'd10, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("rw_req", 32'(DCACHE_REQ), 32'd0);
    check("rw_busy", 32'(MEMORY_BUSY), 32'd0);
    check("rw_wb", WRITE_BACK_DATA, 32'd0);
    @(negedge CLK);
    drive(3'b000, 2'b00, 32'h0, 32'h0, 1'b1, 5'd10, 1'b0);
    RST_N = 1'b1;
    #1 check("rw_idle_req", 32'(DCACHE_REQ), 32'd0);
    @(negedge CLK);
    DCACHE_READY = 1'b1;
    DCACHE_RDATA = 32'h99;
    #1 check("rw_late_req", 32'(DCACHE_REQ), 32'd0);
    @(posedge CLK); #1;
    DCACHE_READY = 1'b0;
    check("rw_no_capture_wb", WRITE_BACK_DATA, 32'd0);
    check("rw_no_capture_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
